// File: rtl/inert_seq.sv
// inert_seq: powers up and configures the inertial sensor over SPI, then reads
// pitch rate and Z accel on each data-ready interrupt and publishes them with vld.
module inert_seq #(
  parameter int INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld,
  output logic        init_cmplt
);
  typedef enum logic [3:0] {
    WAIT_PWR, CFG0, CFG1, CFG2, CFG3, IDLE, RD_PL, RD_PH, RD_AZL, RD_AZH, PUBLISH
  } state_t;
  state_t state_q, state_d;
  logic [INIT_WAIT_BITS-1:0] tmr_q, tmr_d;
  logic int_meta_q, int_s_q;
  logic [7:0] pl_q, pl_d, ph_q, ph_d, azl_q, azl_d;
  logic wrt_q, wrt_d, vld_q, vld_d, init_q, init_d;
  logic [15:0] cmd_q, cmd_d, cmd_nx, ptch_q, ptch_d, az_q, az_d;
  logic xfer_done, unused_hi;
  logic [7:0] rx;
  assign rx = rd_data[7:0];
  assign unused_hi = ^rd_data[15:8];
  // a done arriving while wrt is still high belongs to no started transaction
  assign xfer_done = done & ~wrt_q;
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    pl_d = pl_q;
    ph_d = ph_q;
    azl_d = azl_q;
    init_d = init_q;
    ptch_d = ptch_q;
    az_d = az_q;
    vld_d = 1'b0;
    case (state_q)
      WAIT_PWR: begin
        tmr_d = &tmr_q ? tmr_q : tmr_q + INIT_WAIT_BITS'(1);
        state_d = &tmr_q ? CFG0 : WAIT_PWR;
      end
      CFG0: state_d = xfer_done ? CFG1 : CFG0;
      CFG1: state_d = xfer_done ? CFG2 : CFG1;
      CFG2: state_d = xfer_done ? CFG3 : CFG2;
      CFG3: begin
        state_d = xfer_done ? IDLE : CFG3;
        init_d = init_q | xfer_done;
      end
      IDLE: state_d = int_s_q ? RD_PL : IDLE;
      RD_PL: begin
        state_d = xfer_done ? RD_PH : RD_PL;
        pl_d = xfer_done ? rx : pl_q;
      end
      RD_PH: begin
        state_d = xfer_done ? RD_AZL : RD_PH;
        ph_d = xfer_done ? rx : ph_q;
      end
      RD_AZL: begin
        state_d = xfer_done ? RD_AZH : RD_AZL;
        azl_d = xfer_done ? rx : azl_q;
      end
      RD_AZH: begin
        state_d = xfer_done ? PUBLISH : RD_AZH;
        ptch_d = xfer_done ? {ph_q, pl_q} : ptch_q;
        az_d = xfer_done ? {rx, azl_q} : az_q;
        vld_d = xfer_done;
      end
      PUBLISH: state_d = IDLE;
      default: state_d = WAIT_PWR;
    endcase
    cmd_nx = state_d == CFG0   ? 16'h0D02 :
             state_d == CFG1   ? 16'h1053 :
             state_d == CFG2   ? 16'h1150 :
             state_d == CFG3   ? 16'h1460 :
             state_d == RD_PL  ? 16'hA200 :
             state_d == RD_PH  ? 16'hA300 :
             state_d == RD_AZL ? 16'hAC00 :
             state_d == RD_AZH ? 16'hAD00 : 16'h0000;
    // only transaction states carry a command, and each is entered exactly once per use
    wrt_d = state_d != state_q && cmd_nx != 16'h0000;
    cmd_d = wrt_d ? cmd_nx : cmd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_PWR;
      tmr_q <= '0;
      int_meta_q <= 1'b0;
      int_s_q <= 1'b0;
      pl_q <= '0;
      ph_q <= '0;
      azl_q <= '0;
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
      init_q <= 1'b0;
      cmd_q <= '0;
      ptch_q <= '0;
      az_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      int_meta_q <= INT;
      int_s_q <= int_meta_q;
      pl_q <= pl_d;
      ph_q <= ph_d;
      azl_q <= azl_d;
      wrt_q <= wrt_d;
      vld_q <= vld_d;
      init_q <= init_d;
      cmd_q <= cmd_d;
      ptch_q <= ptch_d;
      az_q <= az_d;
    end
  end
  assign wrt = wrt_q;
  assign cmd = cmd_q;
  assign ptch_rt = ptch_q;
  assign AZ = az_q;
  assign vld = vld_q;
  assign init_cmplt = init_q;
endmodule

// File: tb/tb_inert_seq.sv
// tb_inert_seq: randomized SPI-slave model and command/data scoreboard for inert_seq.
module tb_inert_seq;
  localparam int W = 12;
  localparam int P = 1 << W;
  logic clk, rst_n, INT, done, wrt, vld, init_cmplt;
  logic [15:0] rd_data, cmd, ptch_rt, AZ;
  int n_chk = 0, n_err = 0;
  int cyc = 0, pend = 0, n_wrt = 0, wrt_cnt = 0, vld_cnt = 0, done_rst = 0, rd_cnt = 0;
  int first_wrt_cyc = 0, last_wrt_cyc = 0, azh_done_cyc = 0;
  logic [15:0] pend_cmd = 0;
  logic [7:0] b_pl = 0, b_ph = 0, b_azl = 0, b_azh = 0, byt;
  bit inj = 0, dir = 1, rnd = 0, ph_seen = 0, prev_vld = 0, prev_ic = 0;

  inert_seq #(.INIT_WAIT_BITS(W)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld), .init_cmplt(init_cmplt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_cmd(input int n);
    if (n < 4) return n == 0 ? 16'h0D02 : n == 1 ? 16'h1053 : n == 2 ? 16'h1150 : 16'h1460;
    case ((n - 4) % 4)
      0: return 16'hA200;
      1: return 16'hA300;
      2: return 16'hAC00;
      default: return 16'hAD00;
    endcase
  endfunction

  function automatic logic [7:0] dir_byte(input logic [15:0] c);
    return c == 16'hA200 ? 8'h34 : c == 16'hA300 ? 8'h12 : c == 16'hAC00 ? 8'hCD : 8'hAB;
  endfunction

  // SPI slave model plus scoreboard, acting on the falling edge
  initial begin
    done = 0;
    rd_data = 0;
    forever begin
      @(negedge clk);
      cyc++;
      done = 0;
      if (!rst_n) begin
        pend = 0;
        n_wrt = 0;
        done_rst = 0;
      end else begin
        if (wrt) begin
          chk("one_outstanding", pend != 0, 0);
          chk("cmd", cmd, exp_cmd(n_wrt));
          if (n_wrt == 0) first_wrt_cyc = cyc;
          last_wrt_cyc = cyc;
          n_wrt++;
          wrt_cnt++;
          pend_cmd = cmd;
          pend = rnd ? $urandom_range(1, 25) : 20;
          if (rnd && $urandom_range(0, 3) == 0) begin
            done = 1;
            rd_data = 16'($urandom);
          end
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            byt = dir ? dir_byte(pend_cmd) : 8'($urandom);
            rd_data = {8'($urandom), byt};
            done = 1;
            done_rst++;
            case (pend_cmd)
              16'hA200: b_pl = byt;
              16'hA300: begin b_ph = byt; ph_seen = 1; end
              16'hAC00: b_azl = byt;
              16'hAD00: begin b_azh = byt; azh_done_cyc = cyc; end
              default: ;
            endcase
            if (pend_cmd[15:12] == 4'hA) rd_cnt++;
          end
        end
        if (vld) begin
          chk("vld_1cyc", prev_vld, 0);
          chk("vld_wrt_excl", wrt, 0);
          chk("vld_lat", cyc - azh_done_cyc, 1);
          chk("ptch_rt", ptch_rt, {b_ph, b_pl});
          chk("AZ", AZ, {b_azh, b_azl});
          vld_cnt++;
        end
        if (init_cmplt && !prev_ic) chk("init_after_4_done", done_rst, 4);
      end
      if (inj) begin
        done = 1;
        rd_data = 16'($urandom);
        inj = 0;
      end
      prev_vld = vld;
      prev_ic = init_cmplt;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic power_up(input int c0);
    for (int k = 0; k < P + 300 && !init_cmplt; k++) step(1);
    chk("init_cmplt", init_cmplt, 1);
    chk("first_wrt_window", (first_wrt_cyc - c0 >= P - 1) && (first_wrt_cyc - c0 <= P + 1), 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wrt"}, wrt, 0);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_ptch"}, ptch_rt, 0);
    chk({tag, "_az"}, AZ, 0);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_init"}, init_cmplt, 0);
  endtask

  initial begin
    int c0, v0, w0;
    logic [15:0] p0;
    rst_n = 0;
    INT = 1;
    for (int k = 0; k < 4; k++) begin
      inj = 1;
      step(2);
    end
    chk_reset("rst");
    chk("rst_no_wrt", wrt_cnt, 0);
    INT = 0;
    rst_n = 1;
    c0 = cyc;
    step(50);
    inj = 1;
    step(3);
    chk_reset("wait_pwr_done");
    INT = 1;
    power_up(c0);
    for (int k = 0; k < 10 && n_wrt < 5; k++) step(1);
    chk("read_after_init", n_wrt, 5);
    INT = 0;
    for (int k = 0; k < 200 && vld_cnt < 1; k++) step(1);
    chk("dir_vld", vld_cnt, 1);
    chk("dir_ptch", ptch_rt, 16'h1234);
    chk("dir_az", AZ, 16'hABCD);
    step(1);
    chk("dir_vld_low", vld, 0);
    step(10);
    chk("dir_wrts", wrt_cnt, 8);
    w0 = wrt_cnt;
    v0 = vld_cnt;
    inj = 1;
    step(5);
    chk("idle_done_wrt", wrt_cnt, w0);
    chk("idle_done_vld", vld_cnt, v0);
    chk("idle_done_ptch", ptch_rt, 16'h1234);
    chk("idle_done_az", AZ, 16'hABCD);
    dir = 0;
    INT = 1;
    c0 = cyc;
    for (int k = 0; k < 10 && wrt_cnt == w0; k++) step(1);
    chk("int_lat", last_wrt_cyc - c0, 3);
    for (int k = 0; k < 600 && vld_cnt < v0 + 3; k++) step(1);
    chk("three_bursts", vld_cnt >= v0 + 3, 1);
    INT = 0;
    step(200);
    chk("reads_per_vld", rd_cnt, vld_cnt * 4);
    rnd = 1;
    for (int k = 0; k < 600; k++) begin
      INT = 1'($urandom_range(0, 1));
      step(1);
    end
    INT = 0;
    step(200);
    chk("rnd_reads_per_vld", rd_cnt, vld_cnt * 4);
    rnd = 0;
    ph_seen = 0;
    INT = 1;
    for (int k = 0; k < 300 && !ph_seen; k++) step(1);
    chk("ph_done_seen", ph_seen, 1);
    step(5);
    v0 = vld_cnt;
    p0 = ptch_rt;
    rst_n = 0;
    step(3);
    chk_reset("mid_rst");
    chk("mid_rst_vld_cnt", vld_cnt, v0);
    INT = 0;
    rst_n = 1;
    c0 = cyc;
    power_up(c0);
    chk("no_read_before_init", vld_cnt, v0);
    chk("ptch_discarded", ptch_rt, 0);
    INT = 1;
    for (int k = 0; k < 10 && n_wrt < 5; k++) step(1);
    INT = 0;
    for (int k = 0; k < 200 && vld_cnt < v0 + 1; k++) step(1);
    chk("post_rst_read", vld_cnt, v0 + 1);
    step(20);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL timeout: cycle %0d reached limit", cyc);
    $fatal(1);
  end
endmodule
